// File: rtl/tinyqv_regfile_serial_if.sv
// tinyqv_regfile_serial_if
//   Bus between the tinyQV core (master) and its slice-serial register
//   file (slave).
//   Master -> slave: start, wr_en, rs1, rs2, rd (sampled with start),
//                    data_rd (write data slice for the current cycle).
//   Slave -> master: busy, slice, done, data_rs1, data_rs2 (read slices),
//                    ra_out (parallel x1).
interface tinyqv_regfile_serial_if #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 4,
    parameter int ADDR_W  = 4
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int SL_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    logic                start;
    logic                wr_en;
    logic [ADDR_W-1:0]   rs1;
    logic [ADDR_W-1:0]   rs2;
    logic [ADDR_W-1:0]   rd;
    logic [SLICE_W-1:0]  data_rd;
    logic                busy;
    logic [SL_W-1:0]     slice;
    logic                done;
    logic [SLICE_W-1:0]  data_rs1;
    logic [SLICE_W-1:0]  data_rs2;
    logic [DATA_W-1:0]   ra_out;

    modport master (
        output start, wr_en, rs1, rs2, rd, data_rd,
        input  busy, slice, done, data_rs1, data_rs2, ra_out
    );

    modport slave (
        input  start, wr_en, rs1, rs2, rd, data_rd,
        output busy, slice, done, data_rs1, data_rs2, ra_out
    );
endinterface

// File: rtl/tinyqv_regfile_serial.sv
// tinyqv_regfile_serial
//   Slice-serial register file for the tinyQV core. Each DATA_W-bit operand
//   moves SLICE_W bits per clock, LSB slice first, over two read ports and
//   one write port. The block owns its slice counter and a start/busy/done
//   handshake. Register x1 is also exposed in parallel as ra_out.
//   Ports:
//     clk   - clock, rising edge
//     rstn  - synchronous active-low reset (control state only; register
//             contents are not reset)
//     bus   - tinyqv_regfile_serial_if.slave (start/wr_en/rs1/rs2/rd/data_rd
//             in; busy/slice/done/data_rs1/data_rs2/ra_out out)
//   Configuration macro:
//     TQV_REGFILE_BYPASS_EN - when defined, a read port whose address equals
//     the write address of a writing transfer returns data_rd (new value).
module tinyqv_regfile_serial #(
    parameter int DATA_W   = 32,
    parameter int SLICE_W  = 4,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    tinyqv_regfile_serial_if.slave    bus
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int SL_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [SL_W-1:0] LAST_SLICE = SL_W'(NSLICE - 1);

    logic                busy_q,  busy_d;
    logic [SL_W-1:0]     slice_q, slice_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   rs1_q,   rs1_d;
    logic [ADDR_W-1:0]   rs2_q,   rs2_d;
    logic [ADDR_W-1:0]   rd_q,    rd_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic                done;
    logic                accept;
    logic                wr_slice;
    logic [SLICE_W-1:0]  rd_rs1;
    logic [SLICE_W-1:0]  rd_rs2;

    assign done   = busy_q && (slice_q == LAST_SLICE);
    assign accept = bus.start && (!busy_q || done);

    // Gated by rstn so that the slice in flight on a reset edge is not
    // written: already-written slices keep new data, the rest keep old data.
    assign wr_slice = rstn && busy_q && wr_en_q && (rd_q != '0);

    always_comb begin
        busy_d  = busy_q;
        slice_d = slice_q;
        wr_en_d = wr_en_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;

        if (busy_q) begin
            if (done) begin
                // A start in the last-slice cycle chains straight into the
                // next transfer with no idle bubble.
                slice_d = '0;
                busy_d  = bus.start;
            end else begin
                slice_d = slice_q + 1'b1;
            end
        end else if (bus.start) begin
            busy_d  = 1'b1;
            slice_d = '0;
        end

        if (accept) begin
            wr_en_d = bus.wr_en;
            rs1_d   = bus.rs1;
            rs2_d   = bus.rs2;
            rd_d    = bus.rd;
        end

        if (!rstn) begin
            busy_d  = 1'b0;
            slice_d = '0;
            wr_en_d = 1'b0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
        end
    end

    // Addresses at or above NUM_REGS match no entry, so such writes vanish.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_slice && (rd_q == ADDR_W'(i))) begin
                regs_d[i][int'(slice_q)*SLICE_W +: SLICE_W] = bus.data_rd;
            end
        end
        regs_d[0] = '0;
    end

    // Reads of x0 or of out-of-range addresses fall through to zero.
    always_comb begin
        rd_rs1 = '0;
        rd_rs2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1_q == ADDR_W'(i)) begin
                rd_rs1 = regs_q[i][int'(slice_q)*SLICE_W +: SLICE_W];
            end
            if (rs2_q == ADDR_W'(i)) begin
                rd_rs2 = regs_q[i][int'(slice_q)*SLICE_W +: SLICE_W];
            end
        end
`ifdef TQV_REGFILE_BYPASS_EN
        if (wr_en_q && (rd_q != '0) && (rd_q == rs1_q)) begin
            rd_rs1 = bus.data_rd;
        end
        if (wr_en_q && (rd_q != '0) && (rd_q == rs2_q)) begin
            rd_rs2 = bus.data_rd;
        end
`endif
    end

    always_ff @(posedge clk) begin
        busy_q  <= busy_d;
        slice_q <= slice_d;
        wr_en_q <= wr_en_d;
        rs1_q   <= rs1_d;
        rs2_q   <= rs2_d;
        rd_q    <= rd_d;
        regs_q  <= regs_d;
    end

    assign bus.busy     = busy_q;
    assign bus.slice    = slice_q;
    assign bus.done     = done;
    assign bus.data_rs1 = rd_rs1;
    assign bus.data_rs2 = rd_rs2;

    generate
        if (NUM_REGS >= 2) begin : g_ra
            assign bus.ra_out = regs_q[1];
        end else begin : g_no_ra
            assign bus.ra_out = '0;
        end
    endgenerate
endmodule

// File: tb/tb_tinyqv_regfile_serial.sv
// tb_tinyqv_regfile_serial
//   Directed bench for tinyqv_regfile_serial at default parameters
//   (DATA_W=32, SLICE_W=4, 16 registers). Expected read slices come from a
//   register model and are queued per slice when a transfer is requested.
module tb_tinyqv_regfile_serial;
    logic clk = 1'b0;
    logic rstn;

    tinyqv_regfile_serial_if bus_if ();

    tinyqv_regfile_serial dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [3:0] wd;
        logic [3:0] e1;
        logic [3:0] e2;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [16];
    int          total = 0;
    int          bad   = 0;
    string       phase = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        return (a == 4'd0) ? 32'd0 : model[a];
    endfunction

    // Requests a transfer (drives start and addresses) and queues the
    // expected slice stream; call after checkOutput of the current cycle.
    task automatic applyStimulus(input logic wr, input logic [3:0] rd_a,
                                 input logic [3:0] rs1_a, input logic [3:0] rs2_a,
                                 input logic [31:0] wdata);
        logic [31:0] v1;
        logic [31:0] v2;
        exp_t        e;
        v1 = model_read(rs1_a);
        v2 = model_read(rs2_a);
`ifdef TQV_REGFILE_BYPASS_EN
        if (wr && rd_a != 4'd0 && rd_a == rs1_a) v1 = wdata;
        if (wr && rd_a != 4'd0 && rd_a == rs2_a) v2 = wdata;
`endif
        for (int k = 0; k < 8; k++) begin
            e.k  = k;
            e.wd = wdata[k*4 +: 4];
            e.e1 = v1[k*4 +: 4];
            e.e2 = v2[k*4 +: 4];
            exp_q.push_back(e);
        end
        if (wr && rd_a != 4'd0) model[rd_a] = wdata;
        bus_if.start = 1'b1;
        bus_if.wr_en = wr;
        bus_if.rd    = rd_a;
        bus_if.rs1   = rs1_a;
        bus_if.rs2   = rs2_a;
    endtask

    task automatic tick();
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    // Drives this cycle's write slice, then compares outputs against the
    // scoreboard front (or against idle when nothing is outstanding).
    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            bus_if.data_rd = e.wd;
            #1;
            check("busy",     32'(bus_if.busy),     32'd1);
            check("slice",    32'(bus_if.slice),    32'(e.k));
            check("done",     32'(bus_if.done),     32'(e.k == 7));
            check("data_rs1", 32'(bus_if.data_rs1), 32'(e.e1));
            check("data_rs2", 32'(bus_if.data_rs2), 32'(e.e2));
            exp_q.pop_front();
        end else begin
            bus_if.data_rd = 4'd0;
            #1;
            check("idle.busy",  32'(bus_if.busy),  32'd0);
            check("idle.slice", 32'(bus_if.slice), 32'd0);
            check("idle.done",  32'(bus_if.done),  32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput();
        end
    endtask

    task automatic run_transfer(input logic wr, input logic [3:0] rd_a,
                                input logic [3:0] rs1_a, input logic [3:0] rs2_a,
                                input logic [31:0] wdata);
        applyStimulus(wr, rd_a, rs1_a, rs2_a, wdata);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput();
        end
    endtask

    initial begin
        rstn           = 1'b0;
        bus_if.start   = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.rs1     = 4'd0;
        bus_if.rs2     = 4'd0;
        bus_if.rd      = 4'd0;
        bus_if.data_rd = 4'd0;

        phase = "reset";
        idle(2);
        rstn = 1'b1;
        idle(1);

        phase = "t1_write_read";
        run_transfer(1'b1, 4'd5, 4'd0, 4'd0, 32'hDEADBEEF);
        idle(1);
        run_transfer(1'b0, 4'd0, 4'd5, 4'd0, 32'h0);
        idle(1);

        phase = "t2_x0_ra";
        run_transfer(1'b1, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFF);
        idle(1);
        run_transfer(1'b0, 4'd0, 4'd0, 4'd5, 32'h0);
        idle(1);
        run_transfer(1'b1, 4'd1, 4'd0, 4'd0, 32'h00400010);
        idle(1);
        check("ra_out", bus_if.ra_out, 32'h00400010);

        phase = "t3_back_to_back";
        applyStimulus(1'b1, 4'd2, 4'd5, 4'd0, 32'h12345678);
        for (int c = 0; c < 24; c++) begin
            tick();
            checkOutput();
            if (c == 7)  applyStimulus(1'b0, 4'd0, 4'd2, 4'd1, 32'h0);
            if (c == 15) applyStimulus(1'b1, 4'd3, 4'd2, 4'd5, 32'hCAFEF00D);
        end
        idle(2);

        phase = "t4_start_mid";
        applyStimulus(1'b0, 4'd0, 4'd5, 4'd2, 32'h0);
        for (int c = 0; c < 8; c++) begin
            tick();
            checkOutput();
            if (c == 3) begin
                bus_if.start = 1'b1;
                bus_if.wr_en = 1'b1;
                bus_if.rd    = 4'd5;
                bus_if.rs1   = 4'd1;
            end
        end
        idle(3);
        run_transfer(1'b0, 4'd0, 4'd5, 4'd3, 32'h0);
        idle(1);

        phase = "t5_same_reg";
        run_transfer(1'b1, 4'd7, 4'd0, 4'd0, 32'h11111111);
        idle(1);
        run_transfer(1'b1, 4'd7, 4'd7, 4'd0, 32'h22222222);
        idle(1);
        run_transfer(1'b0, 4'd0, 4'd7, 4'd0, 32'h0);
        idle(1);

        phase = "t6_reset_mid";
        run_transfer(1'b1, 4'd9, 4'd0, 4'd0, 32'h00000000);
        idle(1);
        applyStimulus(1'b1, 4'd9, 4'd0, 4'd0, 32'hAAAAAAAA);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput();
        end
        rstn = 1'b0;
        tick();
        exp_q.delete();
        model[9] = 32'h0000AAAA;
        checkOutput();
        check("rst.data_rs1", 32'(bus_if.data_rs1), 32'd0);
        check("rst.data_rs2", 32'(bus_if.data_rs2), 32'd0);
        rstn = 1'b1;
        idle(1);
        run_transfer(1'b0, 4'd0, 4'd9, 4'd0, 32'h0);
        idle(1);

        phase = "end";
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
